// File: rtl/reg_file_if.sv
// Decoder/register-file bus: read/write addresses, write data, read results and debug port.
interface reg_file_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] rd;
  logic              reg_wr_en;
  logic [XLEN-1:0]   rd_data;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [XLEN-1:0]   dbg_data;

  modport master (
    output rs1, rs2, rd, reg_wr_en, rd_data, dbg_addr,
    input  rs1_data, rs2_data, ready, dbg_data
  );

  modport slave (
    input  rs1, rs2, rd, reg_wr_en, rd_data, dbg_addr,
    output rs1_data, rs2_data, ready, dbg_data
  );
endinterface

// File: rtl/reg_file.sv
// Integer register file: two registered read ports, one write port, x0 hard-wired to zero,
// post-reset clear sequencer. Define REGFILE_BYPASS_EN for write-first same-cycle reads.
module reg_file #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_if.slave   bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [XLEN-1:0]   wr_data_s;

  // Sequencer next state and the single shared write port (clear writes vs. bus writes).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = cnt_q;
    wr_data_s = '0;
    case (state_q)
      CLEAR: begin
        wr_en_s = 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        ready_d = 1'b1;
        if (bus.reg_wr_en && (bus.rd != '0)) begin
          wr_en_s   = 1'b1;
          wr_addr_s = bus.rd;
          wr_data_s = bus.rd_data;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = ADDR_W'(1);
      end
    endcase
  end

  // Read-port next values; outputs stay zero until the clear sequence has finished.
  always_comb begin
    rs1_data_d = '0;
    rs2_data_d = '0;
    if ((state_q == RUN) && (bus.rs1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (bus.reg_wr_en && (bus.rd == bus.rs1)) begin
        rs1_data_d = bus.rd_data;
      end else begin
        rs1_data_d = mem_q[bus.rs1];
      end
`else
      rs1_data_d = mem_q[bus.rs1];
`endif
    end else begin
      rs1_data_d = '0;
    end
    if ((state_q == RUN) && (bus.rs2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (bus.reg_wr_en && (bus.rd == bus.rs2)) begin
        rs2_data_d = bus.rd_data;
      end else begin
        rs2_data_d = mem_q[bus.rs2];
      end
`else
      rs2_data_d = mem_q[bus.rs2];
`endif
    end else begin
      rs2_data_d = '0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= ADDR_W'(1);
      ready_q    <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  // Storage array is not reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  assign bus.rs1_data = rs1_data_q;
  assign bus.rs2_data = rs2_data_q;
  assign bus.ready    = ready_q;
  assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : mem_q[bus.dbg_addr];
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed table, reset/clear corner sequences and
// randomized traffic against an array-based reference model.
module tb_reg_file;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int NCLR   = 31;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  reg_file_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  reg_file #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];
  int clr_left = 0;
  logic [31:0] got1, got2;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wd;
    logic [4:0]  dbg;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [4:0] w,
                                           input logic we, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (BYP && we && (w == a)) return wd;
    return model[a];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.reg_wr_en = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_rs1", bus.rs1_data, 32'd0);
    check("rst_rs2", bus.rs2_data, 32'd0);
    rst = 1'b0;
    clr_left = NCLR;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic cycle(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] w,
                       input logic we, input logic [31:0] wd, input logic [4:0] da);
    logic [31:0] e1, e2;
    bit run_now;
    bus.rs1 = a1; bus.rs2 = a2; bus.rd = w;
    bus.reg_wr_en = we; bus.rd_data = wd; bus.dbg_addr = da;
    run_now = (clr_left == 0);
    e1 = run_now ? ref_read(a1, w, we, wd) : 32'd0;
    e2 = run_now ? ref_read(a2, w, we, wd) : 32'd0;
    @(posedge clk); #1;
    if (run_now && we && (w != 5'd0)) model[w] = wd;
    if (!run_now) clr_left--;
    got1 = bus.rs1_data;
    got2 = bus.rs2_data;
    check("rs1_data", got1, e1);
    check("rs2_data", got2, e2);
    check("ready", {31'd0, bus.ready}, {31'd0, (clr_left == 0)});
    if (clr_left == 0) check("dbg_data", bus.dbg_data, (da == 5'd0) ? 32'd0 : model[da]);
  endtask

  vec_t tbl [9];

  initial begin
    rst = 1'b0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rd = 5'd0;
    bus.reg_wr_en = 1'b0; bus.rd_data = 32'd0; bus.dbg_addr = 5'd0;

    // Clear sequence with a write attempt at clear cycle 10 (must be ignored).
    do_reset();
    for (int i = 0; i < NCLR; i++) begin
      if (i == 10) cycle(5'd3, 5'd3, 5'd3, 1'b1, 32'h0000_0055, 5'd3);
      else cycle(5'(i), 5'(i + 1), 5'(i), 1'b1, 32'hFFFF_0000 | i, 5'd0);
    end
    for (int i = 1; i < 32; i++) begin
      cycle(5'(i), 5'(32 - i), 5'd0, 1'b0, 32'd0, 5'(i));
      check("clear_x", got1, 32'd0);
    end

    tbl[0] = '{5'd0, 5'd0, 5'd5, 1'b1, 32'hDEAD_BEEF, 5'd5, 32'd0, 32'd0};
    tbl[1] = '{5'd5, 5'd0, 5'd0, 1'b0, 32'd0,        5'd5, 32'hDEAD_BEEF, 32'd0};
    tbl[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd0};
    tbl[3] = '{5'd0, 5'd0, 5'd0, 1'b0, 32'd0,        5'd0, 32'd0, 32'd0};
    tbl[4] = '{5'd5, 5'd0, 5'd7, 1'b1, 32'h0000_000A, 5'd7, 32'hDEAD_BEEF, 32'd0};
    tbl[5] = '{5'd7, 5'd7, 5'd7, 1'b1, 32'h1234_5678, 5'd7,
               BYP ? 32'h1234_5678 : 32'h0000_000A, BYP ? 32'h1234_5678 : 32'h0000_000A};
    tbl[6] = '{5'd7, 5'd7, 5'd0, 1'b0, 32'd0,        5'd7, 32'h1234_5678, 32'h1234_5678};
    tbl[7] = '{5'd9, 5'd0, 5'd9, 1'b1, 32'h0000_0077, 5'd9, BYP ? 32'h0000_0077 : 32'd0, 32'd0};
    tbl[8] = '{5'd9, 5'd5, 5'd0, 1'b0, 32'd0,        5'd9, 32'h0000_0077, 32'hDEAD_BEEF};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].we, tbl[i].wd, tbl[i].dbg);
      check($sformatf("tbl%0d_rs1", i), got1, tbl[i].exp1);
      check($sformatf("tbl%0d_rs2", i), got2, tbl[i].exp2);
    end

    // Reset in RUN, then again mid-clear at cycle 15: full 31-cycle clear restarts, x9 gone.
    do_reset();
    for (int i = 0; i < 15; i++) cycle(5'd9, 5'd9, 5'd9, 1'b1, 32'h0000_0099, 5'd0);
    do_reset();
    for (int i = 0; i < NCLR; i++) cycle(5'd9, 5'd5, 5'd0, 1'b0, 32'd0, 5'd0);
    cycle(5'd9, 5'd5, 5'd0, 1'b0, 32'd0, 5'd9);
    check("x9_after_rst", got1, 32'd0);

    // Random traffic on a narrow address range to provoke read/write collisions.
    for (int i = 0; i < 400; i++) begin
      cycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 32'($urandom), 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
